// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command controller: the protocol byte
// codes, the frame-parser state encoding and small checksum/length helpers.
// No ports; imported by uart_cmd_ctrl and uart_cmd_timer.
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  // Protocol byte codes
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] CMD_GO    = 8'h47;

  // Frame parser states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_ADDR_HI  = 3'd2,
    ST_ADDR_LO  = 3'd3,
    ST_LEN      = 3'd4,
    ST_DATA     = 3'd5,
    ST_WAIT_ACK = 3'd6,
    ST_CSUM     = 3'd7
  } state_t;

  // Running modulo-256 checksum accumulate
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // LEN byte to payload count: 0x00 encodes a full 256-byte block
  function automatic logic [8:0] len_decode(input logic [7:0] b);
    return (b == 8'h00) ? 9'd256 : {1'b0, b};
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// ---------------------------------------------------------------------------
// uart_cmd_timer
// Inter-byte timeout counter. Counts clock cycles since the last restart
// while enabled; 'expired' is raised in the TIMEOUT_CLKS-th consecutive
// enabled cycle without a restart.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : clear the count (a byte arrived, or parser is idle)
//   enable     : count only while high; held at zero otherwise
//   expired    : timeout reached this cycle
// ---------------------------------------------------------------------------
module uart_cmd_timer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CLKS - 32'd1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear on restart or while disabled, otherwise saturate at LAST_CNT
  always_comb begin
    cnt_d = cnt_q;
    if (restart || !enable) begin
      cnt_d = 16'd0;
    end else if (cnt_q != LAST_CNT) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving in the same cycle wins over the timeout
  assign expired = enable && !restart && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Parses byte frames from a UART receiver (SYNC, CMD, command fields, CSUM)
// and turns them into memory writes or CPU halt/go control.
//   i_Clock, i_Reset_n        : clock, asynchronous active-low reset
//   i_RX_DV, i_RX_Byte        : received byte strobe and value
//   o_Mem_Wr_Req/i_Mem_Wr_Ack : write handshake, o_Mem_Addr/o_Mem_Data held
//                               stable while the request is up
//   o_Cpu_Halt                : level that stalls the CPU core
//   o_Busy                    : parser is inside a frame
//   o_Frame_Done              : one-cycle pulse on a good checksum
//   o_Err_Csum/Timeout/Overrun: sticky error flags, cleared by i_Err_Clear
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 65535
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_Mem_Wr_Req,
  input  logic        i_Mem_Wr_Ack,
  output logic [15:0] o_Mem_Addr,
  output logic [7:0]  o_Mem_Data,
  output logic        o_Cpu_Halt,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic        o_Err_Csum,
  output logic        o_Err_Timeout,
  output logic        o_Err_Overrun,
  input  logic        i_Err_Clear
);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] addr_q, addr_d;          // address of the next payload byte
  logic [8:0]  remain_q, remain_d;      // payload bytes still to come
  logic        ovr_pend_q, ovr_pend_d;  // overrun seen, abort after ack
  logic        mem_wr_req_q, mem_wr_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        cpu_halt_q, cpu_halt_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        err_csum_q, err_csum_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_overrun_q, err_overrun_d;

  logic [7:0]  csum_next;
  logic        csum_err_set;
  logic        timeout_set;
  logic        overrun_set;
  logic        tmr_restart;
  logic        tmr_enable;
  logic        tmr_expired;

  // The idle state holds the timer cleared, which also covers "restart on
  // entry to IDLE"; memory waits are excluded from the timeout.
  assign tmr_restart = i_RX_DV || (state_q == ST_IDLE);
  assign tmr_enable  = (state_q != ST_IDLE) && (state_q != ST_WAIT_ACK);

  uart_cmd_timer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timer (
    .clk     (i_Clock),
    .rst_n   (i_Reset_n),
    .restart (tmr_restart),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Frame parser next state, datapath updates and error-set strobes
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    csum_d       = csum_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    ovr_pend_d   = ovr_pend_q;
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    cpu_halt_d   = cpu_halt_q;
    frame_done_d = 1'b0;
    csum_err_set = 1'b0;
    timeout_set  = 1'b0;
    overrun_set  = 1'b0;
    csum_next    = csum_add(csum_q, i_RX_Byte);

    case (state_q)
      ST_IDLE: begin
        ovr_pend_d = 1'b0;
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
          state_d = ST_CMD;
          csum_d  = 8'h00;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CMD: begin
        if (i_RX_DV) begin
          cmd_d  = i_RX_Byte;
          csum_d = i_RX_Byte;
          if (i_RX_Byte == CMD_WRITE) begin
            state_d = ST_ADDR_HI;
          end else if ((i_RX_Byte == CMD_HALT) || (i_RX_Byte == CMD_GO)) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_IDLE;  // unknown command: silent abort
          end
        end else begin
          state_d = ST_CMD;
        end
      end

      ST_ADDR_HI: begin
        if (i_RX_DV) begin
          addr_d[15:8] = i_RX_Byte;
          csum_d       = csum_next;
          state_d      = ST_ADDR_LO;
        end else begin
          state_d = ST_ADDR_HI;
        end
      end

      ST_ADDR_LO: begin
        if (i_RX_DV) begin
          addr_d[7:0] = i_RX_Byte;
          csum_d      = csum_next;
          state_d     = ST_LEN;
        end else begin
          state_d = ST_ADDR_LO;
        end
      end

      ST_LEN: begin
        if (i_RX_DV) begin
          remain_d = len_decode(i_RX_Byte);
          csum_d   = csum_next;
          state_d  = ST_DATA;
        end else begin
          state_d = ST_LEN;
        end
      end

      ST_DATA: begin
        if (i_RX_DV) begin
          mem_wr_req_d = 1'b1;
          mem_addr_d   = addr_q;
          mem_data_d   = i_RX_Byte;
          addr_d       = addr_q + 16'd1;  // wraps 0xFFFF -> 0x0000
          remain_d     = remain_q - 9'd1;
          csum_d       = csum_next;
          ovr_pend_d   = 1'b0;
          state_d      = ST_WAIT_ACK;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_WAIT_ACK: begin
        // A byte here cannot be buffered: flag it, drop it, finish the write
        if (i_RX_DV) begin
          overrun_set = 1'b1;
          ovr_pend_d  = 1'b1;
        end else begin
          ovr_pend_d = ovr_pend_q;
        end
        if (i_Mem_Wr_Ack) begin
          mem_wr_req_d = 1'b0;
          if (ovr_pend_q || i_RX_DV) begin
            state_d = ST_IDLE;
          end else if (remain_q == 9'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end

      ST_CSUM: begin
        if (i_RX_DV) begin
          state_d = ST_IDLE;
          if (csum_next == 8'h00) begin
            frame_done_d = 1'b1;
            if (cmd_q == CMD_HALT) begin
              cpu_halt_d = 1'b1;
            end else if (cmd_q == CMD_GO) begin
              cpu_halt_d = 1'b0;
            end else begin
              cpu_halt_d = cpu_halt_q;
            end
          end else begin
            csum_err_set = 1'b1;
          end
        end else begin
          state_d = ST_CSUM;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timer is never enabled in WAIT_ACK, so this cannot cut a pending write
    if (tmr_expired) begin
      state_d     = ST_IDLE;
      timeout_set = 1'b1;
    end else begin
      timeout_set = 1'b0;
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins
  always_comb begin
    err_csum_d    = (err_csum_q    & ~i_Err_Clear) | csum_err_set;
    err_timeout_d = (err_timeout_q & ~i_Err_Clear) | timeout_set;
    err_overrun_d = (err_overrun_q & ~i_Err_Clear) | overrun_set;
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= 8'h00;
      csum_q        <= 8'h00;
      addr_q        <= 16'h0000;
      remain_q      <= 9'd0;
      ovr_pend_q    <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_data_q    <= 8'h00;
      cpu_halt_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      csum_q        <= csum_d;
      addr_q        <= addr_d;
      remain_q      <= remain_d;
      ovr_pend_q    <= ovr_pend_d;
      mem_wr_req_q  <= mem_wr_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      cpu_halt_q    <= cpu_halt_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      err_csum_q    <= err_csum_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign o_Mem_Wr_Req  = mem_wr_req_q;
  assign o_Mem_Addr    = mem_addr_q;
  assign o_Mem_Data    = mem_data_q;
  assign o_Cpu_Halt    = cpu_halt_q;
  assign o_Busy        = busy_q;
  assign o_Frame_Done  = frame_done_q;
  assign o_Err_Csum    = err_csum_q;
  assign o_Err_Timeout = err_timeout_q;
  assign o_Err_Overrun = err_overrun_q;

endmodule
